// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer constants and arbiter type definitions
package fb_pkg;

   localparam int FB_ADDR_W = 12;
   localparam int FB_DATA_W = 12;
   localparam int FB_DEPTH  = 2304;
   localparam int FB_WIDTH  = 48;
   localparam int FB_HEIGHT = 48;

   // Requester id doubles as the bit index into the grant vector.
   typedef enum logic {
      REQ_LOADER = 1'b0,
      REQ_CPU    = 1'b1
   } req_id_e;

   typedef enum logic [1:0] {
      LOCK_NONE   = 2'd0,
      LOCK_LOADER = 2'd1,
      LOCK_CPU    = 2'd2
   } lock_owner_e;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// rtl/fb_port_arbiter_if.sv - one requester's request/response bundle into the framebuffer arbiter
interface fb_port_arbiter_if
   import fb_pkg::*;
#(
   parameter int ADDR_W = FB_ADDR_W,
   parameter int DATA_W = FB_DATA_W
) ();

   logic              valid;
   logic              we;
   logic              lock;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ready;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;

   modport master (
      output valid, we, lock, addr, wdata,
      input  ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  valid, we, lock, addr, wdata,
      output ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/fb_port_arbiter_rr_arb2.sv
// rtl/fb_port_arbiter_rr_arb2.sv - two-way round-robin grant with burst lock
module rr_arb2
   import fb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid_i,
   input  logic [1:0] lock_i,
   output logic [1:0] grant_o
);

   req_id_e     last_grant_q, last_grant_d;
   lock_owner_e lock_owner_q, lock_owner_d;

   // Grant is purely combinational; nothing is granted while reset is held.
   always_comb begin
      grant_o = 2'b00;
      if (!rst) begin
         case (valid_i)
            2'b01: grant_o = 2'b01;
            2'b10: grant_o = 2'b10;
            2'b11: begin
               if (lock_owner_q == LOCK_LOADER)      grant_o = 2'b01;
               else if (lock_owner_q == LOCK_CPU)    grant_o = 2'b10;
               else if (last_grant_q == REQ_CPU)     grant_o = 2'b01;
               else                                  grant_o = 2'b10;
            end
            default: grant_o = 2'b00;
         endcase
      end
   end

   // Next-state: grant history follows transfers; lock is taken on a locked
   // transfer and released once the owner drops valid or lock.
   always_comb begin
      last_grant_d = last_grant_q;
      lock_owner_d = lock_owner_q;

      if (grant_o[REQ_LOADER])   last_grant_d = REQ_LOADER;
      else if (grant_o[REQ_CPU]) last_grant_d = REQ_CPU;

      if (lock_owner_q == LOCK_LOADER && !(valid_i[REQ_LOADER] && lock_i[REQ_LOADER]))
         lock_owner_d = LOCK_NONE;
      if (lock_owner_q == LOCK_CPU && !(valid_i[REQ_CPU] && lock_i[REQ_CPU]))
         lock_owner_d = LOCK_NONE;

      if (grant_o[REQ_LOADER] && lock_i[REQ_LOADER])   lock_owner_d = LOCK_LOADER;
      else if (grant_o[REQ_CPU] && lock_i[REQ_CPU])    lock_owner_d = LOCK_CPU;
   end

   // Arbitration state; reset favours the loader on first contention.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= REQ_CPU;
         lock_owner_q <= LOCK_NONE;
      end else begin
         last_grant_q <= last_grant_d;
         lock_owner_q <= lock_owner_d;
      end
   end

endmodule

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - shares framebuffer RAM port A between image loader and CPU
module fb_port_arbiter
   import fb_pkg::*;
#(
   parameter int ADDR_W = FB_ADDR_W,
   parameter int DATA_W = FB_DATA_W,
   parameter int DEPTH  = FB_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   fb_port_arbiter_if.slave  req0_if,
   fb_port_arbiter_if.slave  req1_if,
   output logic              mem_we_o,
   output logic              mem_re_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              err_oor_o
);

   // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

   logic [1:0]        grant;
   logic              xfer;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              in_range;

   logic rsp0_valid_q, rsp0_valid_d;
   logic rsp1_valid_q, rsp1_valid_d;
   logic rd_oor_q, rd_oor_d;
   logic err_oor_q, err_oor_d;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .valid_i ({req1_if.valid, req0_if.valid}),
      .lock_i  ({req1_if.lock,  req0_if.lock}),
      .grant_o (grant)
   );

   assign req0_if.ready = grant[REQ_LOADER];
   assign req1_if.ready = grant[REQ_CPU];
   assign xfer          = |grant;

   // Mux the granted request onto the RAM side; zeros when idle.
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      if (grant[REQ_CPU]) begin
         sel_we    = req1_if.we;
         sel_addr  = req1_if.addr;
         sel_wdata = req1_if.wdata;
      end else if (grant[REQ_LOADER]) begin
         sel_we    = req0_if.we;
         sel_addr  = req0_if.addr;
         sel_wdata = req0_if.wdata;
      end
   end

   assign in_range    = {1'b0, sel_addr} < DEPTH_EXT;
   assign mem_we_o    = xfer &  sel_we & in_range;
   assign mem_re_o    = xfer & ~sel_we & in_range;
   assign mem_addr_o  = sel_addr;
   assign mem_wdata_o = sel_wdata;

   // Response pipeline inputs: which requester read, and whether it missed the RAM.
   always_comb begin
      rsp0_valid_d = grant[REQ_LOADER] & ~req0_if.we;
      rsp1_valid_d = grant[REQ_CPU]    & ~req1_if.we;
      rd_oor_d     = ~in_range;
      err_oor_d    = xfer & ~in_range;
   end

   // Response and error flags trail the accepted access by one cycle, matching RAM latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rd_oor_q     <= 1'b0;
         err_oor_q    <= 1'b0;
      end else begin
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         rd_oor_q     <= rd_oor_d;
         err_oor_q    <= err_oor_d;
      end
   end

   assign req0_if.rsp_valid = rsp0_valid_q;
   assign req1_if.rsp_valid = rsp1_valid_q;
   assign req0_if.rsp_rdata = rd_oor_q ? '0 : mem_rdata_i;
   assign req1_if.rsp_rdata = rd_oor_q ? '0 : mem_rdata_i;
   assign err_oor_o         = err_oor_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb/tb_fb_port_arbiter.sv - directed scoreboard bench for fb_port_arbiter
module tb_fb_port_arbiter;

   logic        clk;
   logic        rst;
   logic        mem_we;
   logic        mem_re;
   logic [11:0] mem_addr;
   logic [11:0] mem_wdata;
   logic [11:0] mem_rdata;
   logic        err_oor;

   fb_port_arbiter_if #(.ADDR_W(12), .DATA_W(12)) r0 ();
   fb_port_arbiter_if #(.ADDR_W(12), .DATA_W(12)) r1 ();

   fb_port_arbiter #(.ADDR_W(12), .DATA_W(12), .DEPTH(2304)) dut (
      .clk         (clk),
      .rst         (rst),
      .req0_if     (r0),
      .req1_if     (r1),
      .mem_we_o    (mem_we),
      .mem_re_o    (mem_re),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata),
      .err_oor_o   (err_oor)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [11:0] ram [0:4095];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
   end

   int tests = 0;
   int fails = 0;
   int cnt0  = 0;
   int cnt1  = 0;
   logic [11:0] q0[$];
   logic [11:0] q1[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v0, input logic we0, input logic lk0, input logic [11:0] a0, input logic [11:0] d0,
                        input logic v1, input logic we1, input logic lk1, input logic [11:0] a1, input logic [11:0] d1);
      r0.valid = v0; r0.we = we0; r0.lock = lk0; r0.addr = a0; r0.wdata = d0;
      r1.valid = v1; r1.we = we1; r1.lock = lk1; r1.addr = a1; r1.wdata = d1;
   endtask

   // Called at a negedge right after drive(); checks the grant and RAM drive,
   // queues the expected read result, then checks responses one cycle later.
   task automatic cyc(input logic [1:0] exp_g, input logic [11:0] exp_rd);
      logic        we;
      logic [11:0] a;
      logic [11:0] d;
      logic        inr;
      logic        exp_err;
      exp_err = 1'b0;
      #1;
      chk("ready0", r0.ready, exp_g[0]);
      chk("ready1", r1.ready, exp_g[1]);
      if (r0.ready) cnt0++;
      if (r1.ready) cnt1++;
      if (exp_g == 2'b00) begin
         chk("idle_mem_we", mem_we, 1'b0);
         chk("idle_mem_re", mem_re, 1'b0);
      end else begin
         we  = exp_g[1] ? r1.we    : r0.we;
         a   = exp_g[1] ? r1.addr  : r0.addr;
         d   = exp_g[1] ? r1.wdata : r0.wdata;
         inr = (a < 12'd2304);
         exp_err = ~inr;
         chk("mem_we", mem_we, we & inr);
         chk("mem_re", mem_re, ~we & inr);
         chk("mem_addr", mem_addr, a);
         if (we) chk("mem_wdata", mem_wdata, d);
         if (!we) begin
            if (exp_g[1]) q1.push_back(inr ? exp_rd : 12'h000);
            else          q0.push_back(inr ? exp_rd : 12'h000);
         end
      end
      @(posedge clk);
      @(negedge clk);
      if (q0.size() > 0) begin
         chk("rsp0_valid", r0.rsp_valid, 1'b1);
         chk("rsp0_rdata", r0.rsp_rdata, q0.pop_front());
      end else begin
         chk("rsp0_valid", r0.rsp_valid, 1'b0);
      end
      if (q1.size() > 0) begin
         chk("rsp1_valid", r1.rsp_valid, 1'b1);
         chk("rsp1_rdata", r1.rsp_rdata, q1.pop_front());
      end else begin
         chk("rsp1_valid", r1.rsp_valid, 1'b0);
      end
      chk("err_oor", err_oor, exp_err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      drive(1, 1, 0, 12'd5, 12'hABC, 1, 0, 0, 12'd6, 12'h000);
      #1;
      chk("rst_ready0", r0.ready, 1'b0);
      chk("rst_ready1", r1.ready, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_re", mem_re, 1'b0);
      chk("rst_rsp0", r0.rsp_valid, 1'b0);
      chk("rst_rsp1", r1.rsp_valid, 1'b0);
      chk("rst_err", err_oor, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // write then read back on the loader port
      drive(1, 1, 0, 12'd5, 12'hABC, 0, 0, 0, 12'd0, 12'h000); cyc(2'b01, 12'h000);
      drive(1, 0, 0, 12'd5, 12'h000, 0, 0, 0, 12'd0, 12'h000); cyc(2'b01, 12'hABC);
      drive(0, 0, 0, 12'd0, 12'h000, 1, 1, 0, 12'd100, 12'h5A5); cyc(2'b10, 12'h000);

      // strict alternation under continuous contention
      cnt0 = 0; cnt1 = 0;
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, 0, 12'd5, 12'h000, 1, 0, 0, 12'd100, 12'h000);
         if (i % 2 == 0) cyc(2'b01, 12'hABC);
         else            cyc(2'b10, 12'h5A5);
      end
      chk("alt_cnt0", cnt0, 3);
      chk("alt_cnt1", cnt1, 3);

      // burst lock on the loader starves the CPU until lock drops
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 1, 12'(20 + i), 12'(12'h300 + i), 1, 1, 0, 12'd30, 12'h777);
         cyc(2'b01, 12'h000);
      end
      drive(1, 1, 0, 12'd24, 12'h304, 1, 1, 0, 12'd30, 12'h777); cyc(2'b01, 12'h000);
      drive(1, 1, 0, 12'd25, 12'h305, 1, 1, 0, 12'd30, 12'h777); cyc(2'b10, 12'h000);
      drive(0, 0, 0, 12'd0, 12'h000, 0, 0, 0, 12'd0, 12'h000);   cyc(2'b00, 12'h000);
      drive(1, 0, 0, 12'd30, 12'h000, 0, 0, 0, 12'd0, 12'h000);  cyc(2'b01, 12'h777);
      drive(1, 0, 0, 12'd23, 12'h000, 0, 0, 0, 12'd0, 12'h000);  cyc(2'b01, 12'h303);

      // out-of-range read and write
      drive(0, 0, 0, 12'd0, 12'h000, 1, 0, 0, 12'd2304, 12'h000); cyc(2'b10, 12'h000);
      drive(0, 0, 0, 12'd0, 12'h000, 1, 1, 0, 12'd4095, 12'hFFF); cyc(2'b10, 12'h000);
      drive(0, 0, 0, 12'd0, 12'h000, 0, 0, 0, 12'd0, 12'h000);    cyc(2'b00, 12'h000);

      // preload then back-to-back CPU reads
      drive(1, 1, 0, 12'd10, 12'h111, 0, 0, 0, 12'd0, 12'h000); cyc(2'b01, 12'h000);
      drive(1, 1, 0, 12'd11, 12'h222, 0, 0, 0, 12'd0, 12'h000); cyc(2'b01, 12'h000);
      drive(1, 1, 0, 12'd12, 12'h333, 0, 0, 0, 12'd0, 12'h000); cyc(2'b01, 12'h000);
      drive(0, 0, 0, 12'd0, 12'h000, 1, 0, 0, 12'd10, 12'h000); cyc(2'b10, 12'h111);
      drive(0, 0, 0, 12'd0, 12'h000, 1, 0, 0, 12'd11, 12'h000); cyc(2'b10, 12'h222);
      drive(0, 0, 0, 12'd0, 12'h000, 1, 0, 0, 12'd12, 12'h000); cyc(2'b10, 12'h333);

      // leave the loader as last grant, then reset between a read grant and its response
      drive(1, 1, 0, 12'd60, 12'h060, 0, 0, 0, 12'd0, 12'h000); cyc(2'b01, 12'h000);
      drive(1, 0, 1, 12'd10, 12'h000, 0, 0, 0, 12'd0, 12'h000);
      #1;
      chk("pre_rst_ready0", r0.ready, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_ready0", r0.ready, 1'b0);
      chk("mid_rst_mem_re", mem_re, 1'b0);
      chk("mid_rst_mem_we", mem_we, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_rsp0", r0.rsp_valid, 1'b0);
      chk("mid_rst_rsp1", r1.rsp_valid, 1'b0);
      chk("mid_rst_err", err_oor, 1'b0);
      rst = 1'b0;
      drive(1, 1, 0, 12'd50, 12'h050, 1, 1, 0, 12'd51, 12'h051); cyc(2'b01, 12'h000);
      drive(1, 1, 0, 12'd52, 12'h052, 1, 1, 0, 12'd51, 12'h051); cyc(2'b10, 12'h000);
      drive(0, 0, 0, 12'd0, 12'h000, 0, 0, 0, 12'd0, 12'h000);   cyc(2'b00, 12'h000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
